// File: rtl/prog_pkg.sv
// prog_pkg: shared states, widths and byte-slice positions for RAM programming/readback.
package prog_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int HI_MSB = 15;
  localparam int HI_LSB = 8;
  localparam int LO_MSB = 7;
  localparam int LO_LSB = 0;
  typedef enum logic [1:0] {FETCH, WAIT, SHOW_HI, SHOW_LO} state_t;
endpackage

// File: rtl/btn_edge.sv
// btn_edge: one-cycle pulse on each rising edge of a level input.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic pulse
);
  logic q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else q <= d;
  assign pulse = d & ~q;
endmodule

// File: rtl/prog_readback.sv
// prog_readback: steps through program RAM and shows each word on the LEDs, high byte first.
module prog_readback
  import prog_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enter,
  input  logic              load,
  input  logic [7:0]        switch,
  output logic [ADDR_W-1:0] addrRd,
  output logic              rdEn,
  input  logic [DATA_W-1:0] dataRd,
  output logic [7:0]        led,
  output logic              hiSel,
  output logic              valid
);
  state_t state, state_nx;
  logic [1:0] cnt;
  logic [7:0] lo_byte;
  logic ent_p, ld_p, done, show;
  btn_edge u_ent (.clk(clk), .rst(rst), .d(enter), .pulse(ent_p));
  btn_edge u_ld (.clk(clk), .rst(rst), .d(load), .pulse(ld_p));
  assign done = state == WAIT && cnt == 2'd1;
  assign show = state == SHOW_HI || state == SHOW_LO;
  // rst gating keeps the strobe low while held in reset even though state sits at FETCH
  assign rdEn = state == FETCH && rst;
  always_comb begin
    state_nx = state;
    state_nx = state == FETCH ? WAIT :
               state == WAIT ? (done ? SHOW_HI : WAIT) :
               ld_p ? FETCH :
               ent_p ? (state == SHOW_HI ? SHOW_LO : FETCH) : state;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= FETCH;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      addrRd  <= '0;
      cnt     <= '0;
      lo_byte <= '0;
      led     <= '0;
      hiSel   <= 1'b0;
      valid   <= 1'b0;
    end else begin
      if (state == FETCH) cnt <= 2'(RD_LAT);
      else if (state == WAIT) cnt <= cnt - 2'd1;
      if (done) begin
        lo_byte <= dataRd[LO_MSB:LO_LSB];
        led     <= dataRd[HI_MSB:HI_LSB];
        hiSel   <= 1'b1;
        valid   <= 1'b1;
      end
      if (state == SHOW_HI && ent_p && !ld_p) begin
        led   <= lo_byte;
        hiSel <= 1'b0;
      end
      if (show && ld_p) begin
        addrRd <= ADDR_W'(switch);
        valid  <= 1'b0;
      end else if (state == SHOW_LO && ent_p) begin
        addrRd <= addrRd + ADDR_W'(1);
        valid  <= 1'b0;
      end
    end
endmodule

// File: doc/prog_readback.md
Name: prog_readback

Overview:
- Read-side counterpart of the switch/enter RAM programming path; lets the operator step through program RAM and check its contents.
- Issues synchronous reads to the same 256x16 RAM, latches each 16-bit word and shows it on the 8 LEDs one byte at a time.
- Byte order matches entry order: high byte (first entered) is shown first, then the low byte.
- Sits beside the programming logic on the RAM's read port; the top level selects which one drives the board I/O.

Parameters:
- ADDR_W, 8, RAM address width; address wraps modulo 2^ADDR_W.
- DATA_W, 16, RAM word width; must be 16 (two display bytes).
- RD_LAT, 1, RAM read latency in cycles from the rdEn cycle to valid dataRd; legal range 1..3.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- enter  input  1  step button, level; block does its own rising-edge detection.
- load  input  1  address-load button, level; rising-edge detected.
- switch  input  8  start address for load.
- addrRd  output  ADDR_W  RAM read address.
- rdEn  output  1  one-cycle RAM read strobe.
- dataRd  input  DATA_W  RAM read data, valid RD_LAT cycles after rdEn.
- led  output  8  displayed byte.
- hiSel  output  1  1 = led shows high byte, 0 = low byte.
- valid  output  1  1 while a latched word is on display.

Behaviour:
- Reset (rst=0, async): state=FETCH, addrRd=0, rdEn=0, led=0, hiSel=0, valid=0, word register=0, edge-detect history=0.
- Edge detect: pulse = input & ~input_q, with input_q registered each clk. One pulse per press; holding the button gives no repeats.
- FETCH:
  - rdEn=1 for exactly one cycle, addrRd held.
  - Next state WAIT with latency counter = RD_LAT.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 0, capture dataRd into the word register.
  - Next cycle: state=SHOW_HI, valid=1, hiSel=1, led=word[15:8].
  - Fetch-to-display latency after the rdEn cycle is RD_LAT+1 cycles.
- SHOW_HI:
  - enter pulse -> SHOW_LO next cycle, hiSel=0, led=word[7:0]. No new read.
- SHOW_LO:
  - enter pulse -> addrRd=addrRd+1 (255 -> 0 wrap), valid=0, state=FETCH.
- Load pulse in SHOW_HI or SHOW_LO: addrRd=switch, valid=0, state=FETCH.
- Load and enter pulses in the same cycle: load wins; the enter pulse is discarded.
- Pulses arriving in FETCH or WAIT are dropped, not queued.
- During FETCH/WAIT: led keeps its last value and valid=0.
- First display after reset release is mem[0] high byte, with no button press required.
- Reset asserted mid-read: everything returns to reset values immediately; any in-flight read data is ignored.
- Outputs are registered except rdEn, which is decoded from state==FETCH and is glitch-free because state is registered.
- RAM contract: no write-before-read hazard handling; the top level never enables programming and readback at the same time.

Decomposition:
- Package prog_pkg:
  - state enum {FETCH, WAIT, SHOW_HI, SHOW_LO}, 2-bit encoding.
  - ADDR_W/DATA_W defaults.
  - Byte-slice constants HI_MSB=15, HI_LSB=8, LO_MSB=7, LO_LSB=0, shared with the programming logic.
- Sub-module btn_edge: 1-bit rising-edge pulse generator with async active-low reset. Instantiated twice (enter, load); the programming logic can reuse it.

Test Plan:
- RAM model RD_LAT=1 preloaded mem[0]=16'hA55A, release rst -> rdEn pulses once with addrRd=0; 2 cycles later valid=1, hiSel=1, led=8'hA5.
- From that state, press enter -> led=8'h5A, hiSel=0. Press enter again -> addrRd=1, one rdEn, then led=mem[1][15:8].
- switch=8'hFF, press load, mem[255]=16'h1234 -> led=8'h12, then 8'h34. Enter -> addrRd=8'h00, led=8'hA5 (wrap).
- load and enter rise in the same cycle while in SHOW_LO with switch=8'h10 -> addrRd=8'h10, not addr+1. Enter pressed during WAIT -> no state change after display.
- Hold enter high 20 cycles -> exactly one byte step. Repeat with RD_LAT=3 -> rdEn-to-valid latency is 4 cycles.
- Drop rst low during WAIT while the RAM drives 16'hBEEF -> led=0, valid=0, addrRd=0 immediately. After release, mem[0] is displayed and 8'hBE never appears.
